// File: rtl/mdu_pkg.sv
// Shared types and constants for the MIPS multiply/divide sequencer.
package mdu_pkg;

    localparam int unsigned MDU_XLEN  = 32;
    localparam int unsigned MDU_CNT_W = 6;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the MDU core: shift-add multiply or restoring divide.
module mdu_iter_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_acc_hi,
    input  logic [XLEN-1:0] i_acc_lo,
    input  logic [XLEN-1:0] i_opnd,
    output logic [XLEN-1:0] o_acc_hi,
    output logic [XLEN-1:0] o_acc_lo
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic            sub_ok;
    logic [XLEN-1:0] rem_sub;

    // Multiply: acc_hi accumulates, acc_lo holds the multiplier shifting out LSB-first.
    assign add_sum = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_opnd} : (XLEN+1)'(0));

    // Divide: partial remainder in acc_hi, dividend/quotient in acc_lo; difference fits XLEN when sub_ok.
    assign shifted = {i_acc_hi, i_acc_lo[XLEN-1]};
    assign sub_ok  = shifted >= {1'b0, i_opnd};
    assign rem_sub = shifted[XLEN-1:0] - i_opnd;

    always_comb begin
        o_acc_hi = add_sum[XLEN:1];
        o_acc_lo = {add_sum[0], i_acc_lo[XLEN-1:1]};
        if (i_is_div) begin
            o_acc_hi = sub_ok ? rem_sub : shifted[XLEN-1:0];
            o_acc_lo = {i_acc_lo[XLEN-2:0], sub_ok};
        end
    end

endmodule

// File: rtl/mips_mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall and kill.
// Build option MIPS_MDU_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU.
module mips_mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = MDU_XLEN,
    parameter int unsigned CNT_W = MDU_CNT_W
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs,
    input  logic [XLEN-1:0] i_rt,
    input  logic            i_mf_req,
    input  logic            i_mt_hi,
    input  logic            i_mt_lo,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [XLEN-1:0]   rs_q, rs_d, opnd_q, opnd_d;
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    logic              start_signed, start_sign_a, start_sign_b;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic              neg_result;
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    assign start_signed = ~i_op[0];
    assign start_sign_a = start_signed & i_rs[XLEN-1];
    assign start_sign_b = start_signed & i_rt[XLEN-1];
    assign a_mag        = start_sign_a ? -i_rs : i_rs;
    assign b_mag        = start_sign_b ? -i_rt : i_rt;

`ifdef MIPS_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
`endif

    mdu_iter_step #(.XLEN(XLEN)) u_step (
        .i_is_div (op_q[1]),
        .i_acc_hi (acc_hi_q),
        .i_acc_lo (acc_lo_q),
        .i_opnd   (opnd_q),
        .o_acc_hi (step_hi),
        .o_acc_lo (step_lo)
    );

    // Magnitude results are sign-corrected; sign flags are already zero for unsigned ops.
    assign neg_result = sign_a_q ^ sign_b_q;
    assign prod_raw   = {acc_hi_q, acc_lo_q};
    assign prod_fix   = neg_result ? -prod_raw : prod_raw;
    assign quot_fix   = neg_result ? -acc_lo_q : acc_lo_q;
    assign rem_fix    = sign_a_q ? -acc_hi_q : acc_hi_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        rs_d     = rs_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!i_kill) begin
                    if (i_mt_hi) hi_d = i_rs;
                    if (i_mt_lo) lo_d = i_rs;
                    if (i_start) begin
                        op_d     = mdu_op_e'(i_op);
                        sign_a_d = start_sign_a;
                        sign_b_d = start_sign_b;
                        rs_d     = i_rs;
                        opnd_d   = b_mag;
                        acc_hi_d = '0;
                        acc_lo_d = a_mag;
                        cnt_d    = CNT_W'(XLEN);
                        state_d  = S_RUN;
`ifdef MIPS_MDU_FAST_MUL_EN
                        if (!i_op[1]) begin
                            {acc_hi_d, acc_lo_d} = fast_prod;
                            state_d              = S_FIX;
                        end
`endif
                    end
                end
            end
            S_RUN: begin
                if (i_kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!i_kill) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        // Divide by zero returns the original dividend in HI and all-ones in LO.
                        if (opnd_q == '0) begin
                            hi_d = rs_q;
                            lo_d = XLEN'(DIV0_LO);
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quot_fix;
                        end
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= S_IDLE;
            op_q     <= MDU_MULT;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rs_q     <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rs_q     <= rs_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign o_busy  = (state_q != S_IDLE);
    assign o_stall = o_busy & (i_mf_req | i_start | i_mt_hi | i_mt_lo);
    assign o_done  = done_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

endmodule

// File: tb/tb_mips_mdu_sequencer.sv
// Directed self-checking bench for mips_mdu_sequencer: latency, results, stall, kill, MT, reset.
module tb_mips_mdu_sequencer;

`ifdef MIPS_MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_LAT  = 34;
    localparam int DIV_BUSY = 33;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start, mf_req, mt_hi, mt_lo, kill;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mips_mdu_sequencer dut (
        .i_clk    (clk),
        .i_nrst   (nrst),
        .i_start  (start),
        .i_op     (op),
        .i_rs     (rs),
        .i_rt     (rt),
        .i_mf_req (mf_req),
        .i_mt_hi  (mt_hi),
        .i_mt_lo  (mt_lo),
        .i_kill   (kill),
        .o_busy   (busy),
        .o_stall  (stall),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one op at a negedge; return negedges to o_done (0 on timeout) and busy negedges before it.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        lat = 0; busy_n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic op_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input int exp_busy,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, bn;
        run_op(o, a, b, lat, bn);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy"}, 64'(bn), 64'(exp_busy));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int stall_n, done_n;
        nrst = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
        mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; kill = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset stall", 64'(stall), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        nrst = 1'b1;

        // Idle MFHI must not stall
        @(negedge clk); mf_req = 1'b1; #1;
        check("idle mf stall", 64'(stall), 64'(0));
        mf_req = 1'b0;

        op_check("MULT -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, MUL_LAT, MUL_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        op_check("MULT 6*7", 2'b00, 32'd6, 32'd7, MUL_LAT, MUL_BUSY, 32'h0, 32'd42);
        op_check("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, DIV_LAT, DIV_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_check("DIVU 7/2", 2'b11, 32'd7, 32'd2, DIV_LAT, DIV_BUSY, 32'd1, 32'd3);
        op_check("DIVU 5/0", 2'b11, 32'd5, 32'd0, DIV_LAT, DIV_BUSY, 32'd5, 32'hFFFF_FFFF);
        op_check("DIV -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, DIV_LAT, DIV_BUSY, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        op_check("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, DIV_BUSY, 32'h0, 32'h8000_0000);
        op_check("DIVU big", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, DIV_LAT, DIV_BUSY, 32'd1, 32'd1);
        op_check("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, DIV_LAT, DIV_BUSY, 32'd1, 32'hFFFF_FFFD);

        // MULTU with MFLO from E5: stalls through E33, released in the done cycle
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
        stall_n = 0; done_n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 5) mf_req = 1'b1;
            #1;
            if (done) begin
                done_n = i;
                check("MULTU done stall", 64'(stall), 64'(0));
                check("MULTU hi", 64'(hi), 64'(32'hFFFF_FFFE));
                check("MULTU lo", 64'(lo), 64'(32'h0000_0001));
                break;
            end
            if (stall) stall_n++;
        end
        mf_req = 1'b0;
        check("MULTU latency", 64'(done_n), 64'(MUL_LAT));
`ifdef MIPS_MDU_FAST_MUL_EN
        check("MULTU stall cycles", 64'(stall_n), 64'(0));
`else
        check("MULTU stall cycles", 64'(stall_n), 64'(29));
`endif

        // Start while killed in IDLE: op dropped
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 2'b11; rs = 32'd9; rt = 32'd3;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill+start busy", 64'(busy), 64'(0));

        // DIV killed at E10: back to IDLE, HI/LO kept, no done; then MTHI
        @(negedge clk);
        start = 1'b1; op = 2'b10; rs = 32'd100; rt = 32'd7;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("div run busy", 64'(busy), 64'(1));
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", 64'(busy), 64'(0));
        check("kill hi", 64'(hi), 64'(32'hFFFF_FFFE));
        check("kill lo", 64'(lo), 64'(32'h0000_0001));
        mt_hi = 1'b1; rs = 32'h0000_1234;
        done_n = 0;
        @(negedge clk);
        mt_hi = 1'b0;
        check("MTHI hi", 64'(hi), 64'(32'h0000_1234));
        check("MTHI lo", 64'(lo), 64'(32'h0000_0001));
        mt_lo = 1'b1; rs = 32'h0000_ABCD;
        @(negedge clk);
        mt_lo = 1'b0;
        check("MTLO lo", 64'(lo), 64'(32'h0000_ABCD));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("kill no done", 64'(done_n), 64'(0));

        // Busy blocks MTHI with a stall
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs = 32'd20; rt = 32'd6;
        @(negedge clk);
        start = 1'b0; mt_hi = 1'b1; rs = 32'h5555_5555; #1;
        check("busy mt stall", 64'(stall), 64'(1));
        @(negedge clk);
        mt_hi = 1'b0;
        check("busy mt ignored", 64'(hi), 64'(32'h0000_1234));

        // Reset mid-operation
        repeat (3) @(negedge clk);
        nrst = 1'b0; #1;
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset hi", 64'(hi), 64'(0));
        check("midreset lo", 64'(lo), 64'(0));
        @(negedge clk);
        nrst = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset no done", 64'(done), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
